// File: rtl/delay_estimate.sv
// Lag estimator: captures N_SAMP reference/observed sample pairs, then searches
// lags 0..max_lag sequentially for the maximum cross-correlation value.
module delay_estimate #(
    parameter int N_SAMP = 256
) (
    input  logic               clk_in,
    input  logic               reset_n_in,
    input  logic               start_in,
    input  logic               ready_in,
    input  logic signed [15:0] ref_in,
    input  logic signed [15:0] mic_in,
    input  logic [7:0]         max_lag_in,
    output logic               busy_out,
    output logic               done_out,
    output logic [7:0]         delay_out,
    output logic signed [39:0] peak_out,
    output logic [1:0]         fsm_state
);

    localparam int AW = $clog2(N_SAMP);
    localparam logic [AW-1:0] LAST = AW'(N_SAMP - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SEARCH  = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t state;
    state_t state_next;

    logic signed [15:0] ref_buf [N_SAMP];
    logic signed [15:0] mic_buf [N_SAMP];

    logic [AW-1:0]      count;
    logic [AW-1:0]      lag;
    logic [AW-1:0]      n;
    logic [AW-1:0]      max_lag;
    logic               cmp_phase;
    logic signed [39:0] acc;
    logic signed [39:0] best;
    logic [AW-1:0]      best_lag;

    logic [AW-1:0]      lag_clamped;
    logic signed [15:0] rd_ref;
    logic signed [15:0] rd_mic;
    logic signed [31:0] prod;
    logic signed [39:0] acc_sum;
    logic               take;
    logic               last_write;
    logic               last_lag;

    assign fsm_state = state;

    // Largest searchable lag is N_SAMP-1; anything at or above it is clamped.
    assign lag_clamped = ({24'd0, max_lag_in} >= 32'(N_SAMP - 1)) ? LAST : max_lag_in[AW-1:0];

    assign rd_ref  = ref_buf[n - lag];
    assign rd_mic  = mic_buf[n];
    assign prod    = rd_ref * rd_mic;
    assign acc_sum = acc + 40'(prod);

    // Lag 0 always seeds the best value; later lags must strictly exceed it.
    assign take       = (lag == '0) || (acc > best);
    assign last_write = (state == CAPTURE) && ready_in && (count == LAST);
    assign last_lag   = (state == SEARCH) && cmp_phase && (lag == max_lag);

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (start_in) state_next = CAPTURE;
            CAPTURE: if (last_write) state_next = SEARCH;
            SEARCH:  if (last_lag) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy_out = (state == CAPTURE) || (state == SEARCH);
    assign done_out = (state == DONE);

    // ready_in is a pure sample strobe: there is no back-pressure, a sample
    // pair is taken on every rising edge where ready_in=1 while in CAPTURE.
    always_ff @(posedge clk_in) begin
        if (reset_n_in && (state == CAPTURE) && ready_in) begin
            ref_buf[count] <= ref_in;
            mic_buf[count] <= mic_in;
        end
    end

    always_ff @(posedge clk_in) begin
        if (!reset_n_in) begin
            count     <= '0;
            lag       <= '0;
            n         <= '0;
            max_lag   <= '0;
            cmp_phase <= 1'b0;
            acc       <= '0;
            best      <= '0;
            best_lag  <= '0;
            delay_out <= '0;
            peak_out  <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_in) begin
                        max_lag <= lag_clamped;
                        count   <= '0;
                    end
                end
                CAPTURE: begin
                    if (ready_in) begin
                        count <= count + 1'b1;
                        if (count == LAST) begin
                            lag       <= '0;
                            n         <= '0;
                            acc       <= '0;
                            cmp_phase <= 1'b0;
                        end
                    end
                end
                SEARCH: begin
                    if (!cmp_phase) begin
                        acc <= acc_sum;
                        if (n == LAST) begin
                            cmp_phase <= 1'b1;
                        end else begin
                            n <= n + 1'b1;
                        end
                    end else begin
                        if (take) begin
                            best     <= acc;
                            best_lag <= lag;
                        end
                        if (lag == max_lag) begin
                            delay_out <= take ? 8'(lag) : 8'(best_lag);
                            peak_out  <= take ? acc : best;
                        end else begin
                            lag       <= lag + 1'b1;
                            n         <= lag + 1'b1;
                            acc       <= '0;
                            cmp_phase <= 1'b0;
                        end
                    end
                end
                DONE: ;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_delay_estimate.sv
// Bench for delay_estimate: spec vectors from a table, randomized runs against a
// direct correlation model, and hand-written reset/start corner sequences.
module tb_delay_estimate;

    localparam int N = 256;

    logic               clk = 1'b0;
    logic               reset_n;
    logic               start;
    logic               ready;
    logic signed [15:0] ref_d;
    logic signed [15:0] mic_d;
    logic [7:0]         max_lag;
    logic               busy;
    logic               done;
    logic [7:0]         delay;
    logic signed [39:0] peak;
    logic [1:0]         fsm_state;

    int checks = 0;
    int errors = 0;
    int ref_s [N];
    int mic_s [N];

    typedef struct {
        string  name;
        int     pat;
        int     max_lag;
        int     exp_delay;
        longint exp_peak;
        bit     model_peak;
        int     exp_cyc;
    } vec_t;

    vec_t vecs [4];

    always #5 clk = ~clk;

    delay_estimate #(.N_SAMP(N)) dut (
        .clk_in     (clk),
        .reset_n_in (reset_n),
        .start_in   (start),
        .ready_in   (ready),
        .ref_in     (ref_d),
        .mic_in     (mic_d),
        .max_lag_in (max_lag),
        .busy_out   (busy),
        .done_out   (done),
        .delay_out  (delay),
        .peak_out   (peak),
        .fsm_state  (fsm_state)
    );

    task automatic check(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic fill_pattern(input int pat);
        int d;
        d = $urandom_range(0, 6);
        for (int i = 0; i < N; i++) begin
            ref_s[i] = 0;
            mic_s[i] = 0;
        end
        case (pat)
            0: begin
                ref_s[10] = 1000;
                mic_s[60] = 500;
            end
            2: for (int i = 0; i < N; i++) begin
                ref_s[i] = 100;
                mic_s[i] = 100;
            end
            3: begin
                for (int i = 0; i < N; i++) ref_s[i] = ($urandom_range(0, 1) == 1) ? 1000 : -1000;
                for (int i = 0; i < N; i++)
                    mic_s[i] = ((i >= 5) ? -ref_s[i-5] : 0) + ((i >= 20) ? ref_s[i-20] : 0);
            end
            4: begin
                for (int i = 0; i < N; i++) ref_s[i] = int'($urandom_range(0, 16000)) - 8000;
                for (int i = 0; i < N; i++)
                    mic_s[i] = ((i >= d) ? ref_s[i-d] / 2 : 0) + int'($urandom_range(0, 400)) - 200;
            end
            default: ;
        endcase
    endtask

    // Correlation for every lag straight from the definition; ties keep the first lag.
    task automatic model(input int m, output int d, output longint p);
        longint c;
        d = 0;
        p = 0;
        for (int l = 0; l <= m; l++) begin
            c = 0;
            for (int k = 0; k + l < N; k++) c += longint'(ref_s[k]) * longint'(mic_s[k+l]);
            if (l == 0 || c > p) begin
                p = c;
                d = l;
            end
        end
    endtask

    function automatic int search_cycles(input int m);
        return (m + 1) * N - (m * (m + 1)) / 2 + (m + 1);
    endfunction

    task automatic capture(input int m);
        int i;
        @(negedge clk);
        start   = 1'b1;
        ready   = 1'b0;
        max_lag = 8'(m);
        @(negedge clk);
        start   = 1'b0;
        max_lag = 8'($urandom_range(0, 255));
        i = 0;
        while (i < N) begin
            if ($urandom_range(0, 3) != 0) begin
                ready = 1'b1;
                ref_d = 16'(ref_s[i]);
                mic_d = 16'(mic_s[i]);
                i++;
            end else begin
                ready = 1'b0;
                ref_d = 16'($urandom);
                mic_d = 16'($urandom);
            end
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        ready = 1'b0;
        start = 1'b0;
    endtask

    task automatic wait_done(input bit noisy, input int budget, output int meas);
        int cyc;
        cyc = 1;
        while (!done && cyc < budget) begin
            if (noisy) begin
                start   = 1'($urandom_range(0, 1));
                ready   = 1'($urandom_range(0, 1));
                ref_d   = 16'($urandom);
                mic_d   = 16'($urandom);
                max_lag = 8'($urandom_range(0, 255));
            end
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        ready = 1'b0;
        check("done_seen", longint'(done), 1);
        meas = cyc - 1;
    endtask

    task automatic run_vec(input string name, input int m, input int exp_d, input longint exp_p,
                           input bit chk_peak, input int exp_cyc, input bit noisy);
        int meas;
        capture(m);
        wait_done(noisy, exp_cyc + 20, meas);
        check({name, "_cycles"}, longint'(meas), longint'(exp_cyc));
        check({name, "_delay"}, longint'(delay), longint'(exp_d));
        if (chk_peak) check({name, "_peak"}, longint'(peak), exp_p);
        start = 1'b1;
        @(negedge clk);
        check({name, "_done_width"}, longint'(done), 0);
        check({name, "_start_at_done"}, longint'(busy), 0);
        check({name, "_delay_hold"}, longint'(delay), longint'(exp_d));
        start = 1'b0;
        @(negedge clk);
        check({name, "_idle"}, longint'(busy), 0);
    endtask

    initial begin
        int d;
        int m;
        int pulses;
        int busy_seen;
        longint p;

        vecs[0] = '{"impulse", 0, 100, 50, 64'sd500000, 1'b0, 20907};
        vecs[1] = '{"zeros", 1, 255, 0, 64'sd0, 1'b0, 33152};
        vecs[2] = '{"const", 2, 0, 0, 64'sd2560000, 1'b0, 257};
        vecs[3] = '{"anticorr", 3, 25, 20, 64'sd0, 1'b1, 6357};

        reset_n = 1'b0;
        start   = 1'b1;
        ready   = 1'b1;
        ref_d   = 16'sd123;
        mic_d   = -16'sd45;
        max_lag = 8'd0;
        repeat (2) @(negedge clk);
        check("rst_busy", longint'(busy), 0);
        check("rst_done", longint'(done), 0);
        check("rst_delay", longint'(delay), 0);
        check("rst_peak", longint'(peak), 0);
        reset_n = 1'b1;
        start   = 1'b0;
        ready   = 1'b0;
        @(negedge clk);
        check("rst_start_ignored", longint'(busy), 0);

        for (int i = 0; i < 4; i++) begin
            fill_pattern(vecs[i].pat);
            p = vecs[i].exp_peak;
            if (vecs[i].model_peak) model(vecs[i].max_lag, d, p);
            run_vec(vecs[i].name, vecs[i].max_lag, vecs[i].exp_delay, p, 1'b1,
                    vecs[i].exp_cyc, vecs[i].pat == 3);
        end

        repeat (3) begin
            fill_pattern(4);
            m = $urandom_range(0, 6);
            model(m, d, p);
            run_vec("rand", m, d, p, 1'b1, search_cycles(m), 1'b0);
        end

        fill_pattern(4);
        capture(6);
        repeat (100) @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midrst_busy", longint'(busy), 0);
        check("midrst_done", longint'(done), 0);
        check("midrst_delay", longint'(delay), 0);
        check("midrst_peak", longint'(peak), 0);
        reset_n   = 1'b1;
        pulses    = 0;
        busy_seen = 0;
        repeat (300) begin
            @(negedge clk);
            if (done) pulses++;
            if (busy) busy_seen++;
        end
        check("midrst_no_done", longint'(pulses), 0);
        check("midrst_stays_idle", longint'(busy_seen), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/delay_estimate.md
DELAY_ESTIMATE -- requirements
Module: delay_estimate

Interface
REQ-001 SHALL have parameter N_SAMP, default 256: capture window length in samples; N_SAMP is a power of two between 16 and 256.
REQ-002 SHALL have port clk_in, input, 1 bit: sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n_in, input, 1 bit: reset, synchronous and active-low.
REQ-004 SHALL have port start_in, input, 1 bit: single-cycle request to begin a capture and search.
REQ-005 SHALL have port ready_in, input, 1 bit: sample strobe, one cycle per sample pair.
REQ-006 SHALL have port ref_in, input, 16 bits signed: reference signal, i.e. the undelayed source.
REQ-007 SHALL have port mic_in, input, 16 bits signed: observed signal, i.e. the delayed and scaled copy.
REQ-008 SHALL have port max_lag_in, input, 8 bits unsigned: largest lag to search; values of N_SAMP-1 or more are clamped to N_SAMP-1.
REQ-009 SHALL have port busy_out, output, 1 bit: high in CAPTURE and SEARCH.
REQ-010 SHALL have port done_out, output, 1 bit: one-cycle pulse when a result is valid.
REQ-011 SHALL have port delay_out, output, 8 bits unsigned: estimated lag in samples.
REQ-012 SHALL have port peak_out, output, 40 bits signed: correlation value at delay_out.

Function
REQ-013 SHALL implement FSM states IDLE, CAPTURE, SEARCH, DONE.
REQ-014 IDLE, start_in=1 SHALL go to CAPTURE, latch the clamped max_lag_in, and clear the sample counter.
REQ-015 start_in outside IDLE SHALL be ignored; max_lag_in changes after the latch SHALL have no effect.
REQ-016 CAPTURE: each ready_in=1 cycle SHALL write ref_in and mic_in into buffers at address count, then increment count.
REQ-017 CAPTURE: ready_in=0 cycles SHALL leave the buffers and count unchanged.
REQ-018 The write of sample N_SAMP-1 SHALL move the FSM to SEARCH in the next cycle, with lag L=0, n=0, acc=0.
REQ-019 ready_in in IDLE, SEARCH or DONE SHALL be ignored: no buffer writes.
REQ-020 SEARCH SHALL compute C(L) = sum over n=L..N_SAMP-1 of ref[n-L]*mic[n], for each L from 0 to the latched max lag.
REQ-021 Product SHALL be 32-bit signed; acc SHALL be 40-bit signed, sign-extended, with no saturation.
REQ-022 Each lag SHALL take exactly (N_SAMP-L) accumulate cycles plus 1 compare cycle.
REQ-023 Pipelining SHALL be internal and SHALL NOT change the cycle count in REQ-022.
REQ-024 Compare cycle, L=0: best=C(0), best_lag=0 unconditionally.
REQ-025 Compare cycle, L>0: update best and best_lag only if C(L) > best (signed, strict), so ties keep the smaller lag.
REQ-026 After the compare for L = max lag, the FSM SHALL go to DONE; otherwise L increments, n=L, acc=0.
REQ-027 DONE SHALL last one cycle: done_out=1, delay_out=best_lag, peak_out=best, then IDLE.
REQ-028 delay_out and peak_out SHALL change only on entry to DONE and hold until the next result or reset.
REQ-029 done_out SHALL be 0 in all states except DONE.
REQ-030 A start_in arriving in the same cycle as the DONE-to-IDLE transition SHALL be ignored; start_in is accepted only while the FSM is in IDLE.
REQ-031 A new run SHALL fully overwrite the buffers before SEARCH; no data from a prior run SHALL be used.

Reset
REQ-032 reset_n_in=0 at a clock edge SHALL force IDLE and clear count, L, n, acc, best and best_lag.
REQ-033 The same reset SHALL clear busy_out=0, done_out=0, delay_out=0, peak_out=0.
REQ-034 Reset SHALL take priority over all other inputs in any state, including mid-CAPTURE and mid-SEARCH.
REQ-035 Buffer contents need not be cleared on reset.

Verification
REQ-036 Reset: hold reset_n_in=0 for 2 cycles -> all outputs 0, busy_out=0, and start_in during reset is ignored.
REQ-037 Impulse pair: ref impulse of 1000 at n=10, mic impulse of 500 at n=60, all else 0, max_lag=100 -> one done_out pulse, delay_out=50, peak_out=500000.
REQ-038 All-zero inputs, max_lag=255 -> delay_out=0 (tie rule), peak_out=0, done exactly 32896+256 cycles after SEARCH entry.
REQ-039 max_lag=0, ref=mic=100 constant -> delay_out=0, peak_out=2560000, done 257 cycles after SEARCH entry.
REQ-040 Reset asserted mid-SEARCH -> next cycle IDLE, busy_out=0, outputs 0, no done_out pulse.
REQ-041 start_in and ready_in with alternate data during SEARCH; anti-correlated lag (mic=-ref at lag 5, +ref at lag 20) -> result unaffected, delay_out=20.
